// File: rtl/multiword_add_seq_pkg.sv
// Shared types and helpers for the slice-sequenced multiword adder.
// State encoding matches the datapath-wide FSM numbering (IDLE=0, RUN=1, DONE=2).
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice counter width; kept at least one bit so WORDS=1 still has a legal register.
    function automatic int cnt_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/multiword_add_seq_adder.sv
// N-bit ripple-carry adder slice with carry-in/out and N/C/V flags of its own top bit.
// The carry into the MSB is kept so overflow can be formed as carry[N] ^ carry[N-1].
module multiword_add_seq_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         flag_n_o,
    output logic         flag_c_o,
    output logic         flag_v_o
);

    logic carry;
    logic carry_msb;

    always_comb begin
        carry     = cin_i;
        carry_msb = 1'b0;
        sum_o     = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) carry_msb = carry;
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o   = carry;
    assign flag_n_o = sum_o[N-1];
    assign flag_c_o = carry;
    assign flag_v_o = carry ^ carry_msb;

endmodule

// File: rtl/multiword_add_seq.sv
// Adds/subtracts WORDS*SLICE_W-bit operands through one shared SLICE_W-bit adder,
// LS slice first, carry chained through a register; result and N/Z/C/V over valid/ready.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int SLICE_W = 8,
    parameter int WORDS   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       flag_n,
    output logic                       flag_z,
    output logic                       flag_c,
    output logic                       flag_v
);

    localparam int W  = SLICE_W * WORDS;
    localparam int CW = cnt_width(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t          state_q;
    logic [W-1:0]    opa_q, opb_q, res_q, res_d, sum_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q, zacc_q;
    logic            in_ready_q, out_valid_q;
    logic            n_q, z_q, c_q, v_q;

    logic [SLICE_W-1:0] opa_w [WORDS];
    logic [SLICE_W-1:0] opb_w [WORDS];
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout, slice_n, slice_c, slice_v;
    logic               slice_zero;

    for (genvar i = 0; i < WORDS; i++) begin : g_slice
        assign opa_w[i] = opa_q[i*SLICE_W +: SLICE_W];
        assign opb_w[i] = opb_q[i*SLICE_W +: SLICE_W];
    end

    multiword_add_seq_adder #(.N(SLICE_W)) u_slice (
        .a_i      (opa_w[cnt_q]),
        .b_i      (opb_w[cnt_q]),
        .cin_i    (carry_q),
        .sum_o    (slice_sum),
        .cout_o   (slice_cout),
        .flag_n_o (slice_n),
        .flag_c_o (slice_c),
        .flag_v_o (slice_v)
    );

    assign slice_zero = (slice_sum == '0);

    // New slice enters at the top; after WORDS shifts the LS slice sits at bit 0.
    if (WORDS == 1) begin : g_res_one
        assign res_d = slice_sum;
    end else begin : g_res_multi
        assign res_d = {slice_sum, res_q[W-1:SLICE_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        opa_q      <= a;
                        opb_q      <= b ^ {W{sub}};
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        zacc_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_q   <= res_d;
                    carry_q <= slice_cout;
                    zacc_q  <= zacc_q & slice_zero;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        sum_q       <= res_d;
                        n_q         <= slice_n;
                        z_q         <= zacc_q & slice_zero;
                        c_q         <= slice_c;
                        v_q         <= slice_v;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;

endmodule
